npu_v2_chip_model: RTL and testbench

- Cycle-based behavioural model of the NPU v2 RRAM crossbar chip (MAX_NUM_WL word lines × MAX_NUM_BL bit lines) used as the chip-side load for the NPU controller in simulation.
- Accepts 6-bit WL input voltages through the DAC path and bit-line enables through four ring-switch shift chains.
- Computes a quantized vector-matrix product per bit line and returns it on DOUT through the ADC path.
- All pin activity is sampled synchronously on clk_all.

---
 rtl/npu_v2_chip_model_if.sv | 38 +++
 rtl/npu_v2_chip_model.sv | 161 ++++++++++++++++
 tb/tb_npu_v2_chip_model.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_v2_chip_model_if.sv
// Pin bundle between the NPU controller (master) and the crossbar chip model (slave).
interface npu_v2_chip_model_if;
  logic [7:0]  DIN;
  logic [8:0]  ADDR;
  logic        CLKDAC;
  logic        CLKADC;
  logic [5:0]  DOUT;
  logic [3:0]  CLKREG;
  logic [3:0]  DINSWREG;
  logic        DACWL_SW;
  logic        DACBL_SW2;
  logic        DACBL_SW;
  logic        DACSEL_SW;
  logic        DACWLREFSW;
  logic        CLKADCSW;
  logic        SET;
  logic        RESET;
  logic        ASET_WLREG;
  logic        DISCHG;
  logic        ARST_WLREG;
  logic        ARST_ENREG;
  logic        ASET_ENREG;
  logic [31:0] NPU_model_Q_values;

  modport master (
    output DIN, ADDR, CLKDAC, CLKADC, CLKREG, DINSWREG, DACWL_SW, DACBL_SW2,
           DACBL_SW, DACSEL_SW, DACWLREFSW, CLKADCSW, SET, RESET, ASET_WLREG,
           DISCHG, ARST_WLREG, ARST_ENREG, ASET_ENREG,
    input  DOUT, NPU_model_Q_values
  );

  modport slave (
    input  DIN, ADDR, CLKDAC, CLKADC, CLKREG, DINSWREG, DACWL_SW, DACBL_SW2,
           DACBL_SW, DACSEL_SW, DACWLREFSW, CLKADCSW, SET, RESET, ASET_WLREG,
           DISCHG, ARST_WLREG, ARST_ENREG, ASET_ENREG,
    output DOUT, NPU_model_Q_values
  );
endinterface

// File: rtl/npu_v2_chip_model.sv
// Cycle-based model of the NPU v2 RRAM crossbar: WL inputs via the DAC pins, BL enables via
// four ring-switch chains, and a quantized per-BL dot product returned on DOUT.
module npu_v2_chip_model #(
  parameter int unsigned MAX_NUM_BL      = 256,
  parameter int unsigned MAX_NUM_WL      = 256,
  parameter int unsigned MODEL_WEIGHT_BL = 32,
  parameter int unsigned MODEL_WEIGHT_WL = 32,
  parameter int unsigned Q_INTERVAL      = 906,
  parameter int unsigned Q_DEDUCT        = 0
) (
  input logic               clk_all,
  input logic               reset_all,
  npu_v2_chip_model_if.slave pins
);

  localparam int          LANES        = 32'sd4;
  localparam int          LANE_LEN     = int'(MAX_NUM_BL) / LANES;
  localparam int          WL_AW        = $clog2(MAX_NUM_WL);
  localparam int          BL_AW        = $clog2(MAX_NUM_BL);
  localparam logic [31:0] Q_INTERVAL_L = 32'(Q_INTERVAL);
  localparam logic [31:0] Q_DEDUCT_L   = 32'(Q_DEDUCT);

  logic [5:0]            wl_in_r [MAX_NUM_WL];
  logic [MAX_NUM_BL-1:0] en_r;
  logic [MAX_NUM_BL-1:0] en_next_s;
  logic                  dac_prev_r;
  logic                  adc_prev_r;
  logic [3:0]            reg_prev_r;
  logic [5:0]            dout_r;
  logic [5:0]            dout_next_s;

  logic                  dac_fire_s;
  logic                  adc_fire_s;
  logic [3:0]            reg_rise_s;
  logic                  wl_ok_s;
  logic                  bl_ok_s;
  logic                  en_sel_s;
  logic                  wl_clr_s;
  logic [WL_AW-1:0]      wl_idx_s;
  logic [BL_AW-1:0]      bl_idx_s;
  logic [31:0]           addr_s;
  logic [31:0]           acc_s;
  logic [31:0]           q_s;
  logic [LANE_LEN-1:0]   lane_s;
  logic                  unused_s;

  // Fixed crossbar conductance pattern; only the top-left corner carries weight.
  function automatic logic [3:0] weight_f(input logic [31:0] wl, input logic [31:0] bl);
    if ((wl < MODEL_WEIGHT_WL) && (bl < MODEL_WEIGHT_BL)) begin
      weight_f = 4'(wl + bl + bl);
    end else begin
      weight_f = 4'd0;
    end
  endfunction

  assign dac_fire_s = pins.CLKDAC & ~dac_prev_r;
  assign adc_fire_s = pins.CLKADC & ~adc_prev_r;
  assign reg_rise_s = pins.CLKREG & ~reg_prev_r;
  assign addr_s     = 32'(pins.ADDR);
  assign wl_ok_s    = addr_s < MAX_NUM_WL;
  assign bl_ok_s    = addr_s < MAX_NUM_BL;
  assign wl_idx_s   = pins.ADDR[WL_AW-1:0];
  assign bl_idx_s   = pins.ADDR[BL_AW-1:0];
  assign en_sel_s   = bl_ok_s & en_r[bl_idx_s];
  assign wl_clr_s   = pins.DISCHG | pins.ARST_WLREG;

  assign pins.DOUT               = dout_r;
  assign pins.NPU_model_Q_values = {Q_INTERVAL_L[15:0], Q_DEDUCT_L[15:0]};

  assign unused_s = ^{pins.DIN[7:6], pins.DACBL_SW, pins.DACSEL_SW, pins.DACWLREFSW,
                      pins.CLKADCSW, pins.SET, pins.RESET, pins.ASET_WLREG};

  // Dot product of all WL inputs with the weight column of the addressed bit line
  always_comb begin
    acc_s = 32'd0;
    for (int wl = 32'sd0; wl < int'(MAX_NUM_WL); wl++) begin
      acc_s = acc_s + 32'(wl_in_r[wl]) * 32'(weight_f(32'(wl), addr_s));
    end
  end

  // ADC transfer: offset, truncating divide, clamp to 6 bits
  always_comb begin
    dout_next_s = 6'd0;
    q_s         = 32'd0;
    if (!en_sel_s) begin
      dout_next_s = 6'd0;
    end else if (acc_s <= Q_DEDUCT_L) begin
      dout_next_s = 6'd0;
    end else begin
      q_s = (acc_s - Q_DEDUCT_L) / Q_INTERVAL_L;
      if (q_s > 32'd63) begin
        dout_next_s = 6'd63;
      end else begin
        dout_next_s = q_s[5:0];
      end
    end
  end

  // Next BL enables: global clear beats global set beats per-lane shifting
  always_comb begin
    en_next_s = en_r;
    lane_s    = '0;
    if (pins.ARST_ENREG) begin
      en_next_s = '0;
    end else if (pins.ASET_ENREG) begin
      en_next_s = '1;
    end else begin
      for (int k = 32'sd0; k < LANES; k++) begin
        lane_s = en_r[k*LANE_LEN +: LANE_LEN];
        if (reg_rise_s[k]) begin
          en_next_s[k*LANE_LEN +: LANE_LEN] = {lane_s[LANE_LEN-2:0], pins.DINSWREG[k]};
        end else begin
          en_next_s[k*LANE_LEN +: LANE_LEN] = lane_s;
        end
      end
    end
  end

  // Strobe history for rising-edge detection
  always_ff @(posedge clk_all or posedge reset_all) begin
    if (reset_all) begin
      dac_prev_r <= 1'b0;
      adc_prev_r <= 1'b0;
      reg_prev_r <= 4'd0;
    end else begin
      dac_prev_r <= pins.CLKDAC;
      adc_prev_r <= pins.CLKADC;
      reg_prev_r <= pins.CLKREG;
    end
  end

  // WL input registers; a level clear wins over a DAC write in the same cycle
  always_ff @(posedge clk_all or posedge reset_all) begin
    if (reset_all) begin
      for (int i = 32'sd0; i < int'(MAX_NUM_WL); i++) wl_in_r[i] <= 6'd0;
    end else if (wl_clr_s) begin
      for (int i = 32'sd0; i < int'(MAX_NUM_WL); i++) wl_in_r[i] <= 6'd0;
    end else if (dac_fire_s && pins.DACWL_SW && wl_ok_s) begin
      wl_in_r[wl_idx_s] <= pins.DIN[5:0];
    end
  end

  // BL enable chains
  always_ff @(posedge clk_all or posedge reset_all) begin
    if (reset_all) begin
      en_r <= '0;
    end else begin
      en_r <= en_next_s;
    end
  end

  // ADC result register, sampled from pre-edge WL inputs and enables
  always_ff @(posedge clk_all or posedge reset_all) begin
    if (reset_all) begin
      dout_r <= 6'd0;
    end else if (adc_fire_s && pins.DACBL_SW2) begin
      dout_r <= dout_next_s;
    end
  end

endmodule

// File: tb/tb_npu_v2_chip_model.sv
// Self-checking bench: four chip models with different weight/quantizer settings share one
// pin stimulus and are compared against a behavioural crossbar model.
module tb_npu_v2_chip_model;

  // Packed so element [g] is config g: {c3, c2, c1, c0}
  localparam logic [3:0][31:0] QI   = {32'd906, 32'd1, 32'd10, 32'd906};
  localparam logic [3:0][31:0] QD   = {32'd20000, 32'd0, 32'd0, 32'd0};
  localparam logic [3:0][31:0] MWBL = {32'd32, 32'd32, 32'd256, 32'd32};

  logic clk = 1'b0;
  logic rst;
  logic [7:0] din;
  logic [8:0] addr;
  logic clkdac, clkadc, dacwl_sw, dacbl_sw2, dischg, arst_wlreg, arst_enreg, aset_enreg;
  logic [3:0] clkreg, dinswreg;
  logic [5:0] dout [4];
  logic [31:0] qv [4];

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  wl_m [256];
  logic [63:0] lane_m [4];
  logic [5:0]  dout_m [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    npu_v2_chip_model_if bus ();
    assign bus.DIN        = din;
    assign bus.ADDR       = addr;
    assign bus.CLKDAC     = clkdac;
    assign bus.CLKADC     = clkadc;
    assign bus.CLKREG     = clkreg;
    assign bus.DINSWREG   = dinswreg;
    assign bus.DACWL_SW   = dacwl_sw;
    assign bus.DACBL_SW2  = dacbl_sw2;
    assign bus.DACBL_SW   = 1'b0;
    assign bus.DACSEL_SW  = 1'b0;
    assign bus.DACWLREFSW = 1'b0;
    assign bus.CLKADCSW   = 1'b0;
    assign bus.SET        = 1'b0;
    assign bus.RESET      = 1'b0;
    assign bus.ASET_WLREG = 1'b0;
    assign bus.DISCHG     = dischg;
    assign bus.ARST_WLREG = arst_wlreg;
    assign bus.ARST_ENREG = arst_enreg;
    assign bus.ASET_ENREG = aset_enreg;
    assign dout[g]        = bus.DOUT;
    assign qv[g]          = bus.NPU_model_Q_values;

    npu_v2_chip_model #(
      .MAX_NUM_BL(256), .MAX_NUM_WL(256),
      .MODEL_WEIGHT_BL(MWBL[g]), .MODEL_WEIGHT_WL(32),
      .Q_INTERVAL(QI[g]), .Q_DEDUCT(QD[g])
    ) dut (
      .clk_all(clk), .reset_all(rst), .pins(bus)
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [5:0] model_q(input int g, input int bl);
    longint acc, q;
    if (bl >= 256) return 6'd0;
    if (lane_m[bl / 64][bl % 64] == 1'b0) return 6'd0;
    acc = 0;
    for (int wl = 0; wl < 256; wl++)
      if (wl < 32 && bl < int'(MWBL[g])) acc += longint'(wl_m[wl]) * ((wl + 2 * bl) % 16);
    if (acc <= longint'(QD[g])) return 6'd0;
    q = (acc - longint'(QD[g])) / longint'(QI[g]);
    return (q > 63) ? 6'd63 : 6'(q);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) wl_m[i] = 6'd0;
    for (int k = 0; k < 4; k++) lane_m[k] = 64'd0;
    for (int g = 0; g < 4; g++) dout_m[g] = 6'd0;
  endtask

  // ---------------- pin drivers (called at negedge) ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dac_write(input int a, input logic [7:0] d, input logic sw);
    addr = 9'(a); din = d; dacwl_sw = sw; clkdac = 1'b1;
    tick();
    clkdac = 1'b0; dacwl_sw = 1'b0;
    tick();
    if (sw && a < 256) wl_m[a] = d[5:0];
  endtask

  task automatic shift_lanes(input logic [3:0] mask, input logic [3:0] bits);
    clkreg = mask; dinswreg = bits;
    tick();
    clkreg = 4'd0;
    tick();
    for (int k = 0; k < 4; k++)
      if (mask[k]) lane_m[k] = {lane_m[k][62:0], bits[k]};
  endtask

  task automatic adc(input int a, input logic sw2);
    addr = 9'(a); dacbl_sw2 = sw2; clkadc = 1'b1;
    tick();
    clkadc = 1'b0; dacbl_sw2 = 1'b0;
    tick();
    if (sw2) for (int g = 0; g < 4; g++) dout_m[g] = model_q(g, a);
  endtask

  task automatic en_clear();
    arst_enreg = 1'b1; tick(); arst_enreg = 1'b0; tick();
    for (int k = 0; k < 4; k++) lane_m[k] = 64'd0;
  endtask

  task automatic en_set();
    aset_enreg = 1'b1; tick(); aset_enreg = 1'b0; tick();
    for (int k = 0; k < 4; k++) lane_m[k] = '1;
  endtask

  task automatic discharge();
    dischg = 1'b1; tick(); dischg = 1'b0; tick();
    for (int i = 0; i < 256; i++) wl_m[i] = 6'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] exp_qv [4];
    exp_qv = '{32'h038A_0000, 32'h000A_0000, 32'h0001_0000, 32'h038A_4E20};
    rst = 1'b1;
    tick(); tick();
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== 6'd0) begin
        n_fail++; $display("FAIL reset_dout[%0d] got %0d expected 0", g, dout[g]);
      end
      n_checks++;
      if (qv[g] !== exp_qv[g]) begin
        n_fail++; $display("FAIL q_values[%0d] got %h expected %h", g, qv[g], exp_qv[g]);
      end
    end
    rst = 1'b0;
    model_reset();
    tick();
    dac_write(0, 8'd63, 1'b1);
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== 6'd0) begin
        n_fail++; $display("FAIL reset_en_off[%0d] got %0d expected 0", g, dout[g]);
      end
    end
  endtask

  task automatic test_basic_compute();
    logic [5:0] exp_lit [4];
    exp_lit = '{6'd0, 6'd24, 6'd63, 6'd0};
    discharge();
    for (int wl = 0; wl < 32; wl++) dac_write(wl, 8'd1, 1'b1);
    en_clear();
    shift_lanes(4'b0001, 4'b0001);
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== exp_lit[g]) begin
        n_fail++; $display("FAIL basic[%0d] got %0d expected %0d", g, dout[g], exp_lit[g]);
      end
    end
  endtask

  task automatic test_full_scale();
    logic [5:0] exp_lit [4];
    exp_lit = '{6'd16, 6'd63, 6'd63, 6'd0};
    for (int wl = 0; wl < 32; wl++) dac_write(wl, 8'd63, 1'b1);
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== exp_lit[g]) begin
        n_fail++; $display("FAIL full_scale[%0d] got %0d expected %0d", g, dout[g], exp_lit[g]);
      end
    end
  endtask

  task automatic test_enables();
    logic [5:0] exp_on [4];
    logic [5:0] exp_l3 [4];
    exp_on = '{6'd16, 6'd63, 6'd63, 6'd0};
    exp_l3 = '{6'd0, 6'd63, 6'd0, 6'd0};
    en_clear();
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== 6'd0) begin
        n_fail++; $display("FAIL en_cleared[%0d] got %0d expected 0", g, dout[g]);
      end
    end
    en_set();
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== exp_on[g]) begin
        n_fail++; $display("FAIL en_set[%0d] got %0d expected %0d", g, dout[g], exp_on[g]);
      end
    end
    en_clear();
    shift_lanes(4'b1000, 4'b1000);
    adc(192, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== exp_l3[g]) begin
        n_fail++; $display("FAIL lane3_bl192[%0d] got %0d expected %0d", g, dout[g], exp_l3[g]);
      end
    end
    foreach (exp_l3[j]) begin
      adc((j == 0) ? 0 : (j == 1) ? 193 : (j == 2) ? 191 : 128, 1'b1);
      for (int g = 0; g < 4; g++) begin
        n_checks++;
        if (dout[g] !== dout_m[g]) begin
          n_fail++; $display("FAIL lane3_other[%0d] got %0d expected %0d", g, dout[g], dout_m[g]);
        end
      end
    end
  endtask

  task automatic test_clear_gating();
    logic [5:0] exp_g [4];
    exp_g = '{6'd0, 6'd18, 6'd63, 6'd0};
    en_set();
    discharge();
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== 6'd0) begin
        n_fail++; $display("FAIL discharge[%0d] got %0d expected 0", g, dout[g]);
      end
    end
    dac_write(3, 8'd63, 1'b0);
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== dout_m[g]) begin
        n_fail++; $display("FAIL dac_gated[%0d] got %0d expected %0d", g, dout[g], dout_m[g]);
      end
    end
    dac_write(3, 8'd63, 1'b1);
    adc(0, 1'b1);
    dac_write(4, 8'd63, 1'b1);
    adc(0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== exp_g[g]) begin
        n_fail++; $display("FAIL adc_gated_hold[%0d] got %0d expected %0d", g, dout[g], exp_g[g]);
      end
    end
  endtask

  task automatic test_edge_handling();
    discharge();
    addr = 9'd5; dacwl_sw = 1'b1; din = 8'd63; clkdac = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      din = 8'($urandom_range(0, 62));
      tick();
    end
    clkdac = 1'b0; dacwl_sw = 1'b0;
    tick();
    wl_m[5] = 6'd63;
    adc(0, 1'b1);
    n_checks++;
    if (dout[1] !== 6'd31) begin
      n_fail++; $display("FAIL dac_held_once got %0d expected 31", dout[1]);
    end
    dac_write(300, 8'd63, 1'b1);
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== dout_m[g]) begin
        n_fail++; $display("FAIL dac_addr300[%0d] got %0d expected %0d", g, dout[g], dout_m[g]);
      end
    end
    // CLKADC held high while ADDR moves out of range: only the first address is converted
    adc(300, 1'b1);
    addr = 9'd0; dacbl_sw2 = 1'b1; clkadc = 1'b1;
    tick();
    addr = 9'd300;
    tick(); tick(); tick();
    clkadc = 1'b0; dacbl_sw2 = 1'b0;
    tick();
    n_checks++;
    if (dout[1] !== 6'd31) begin
      n_fail++; $display("FAIL adc_held_once got %0d expected 31", dout[1]);
    end
    adc(300, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== 6'd0) begin
        n_fail++; $display("FAIL adc_addr300[%0d] got %0d expected 0", g, dout[g]);
      end
    end
  endtask

  task automatic test_random();
    int op, a, bl;
    en_clear();
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 40);
        dac_write(a, 8'($urandom), 1'b1);
      end else if (op <= 7) begin
        shift_lanes(4'($urandom), 4'($urandom));
      end else if (op == 8) begin
        en_set();
      end else begin
        if ($urandom_range(0, 3) == 0) discharge();
        else dac_write($urandom_range(0, 31), 8'd63, 1'b1);
      end
      case ($urandom_range(0, 3))
        0:       bl = $urandom_range(0, 3);
        1:       bl = $urandom_range(0, 40);
        2:       bl = $urandom_range(190, 200);
        default: bl = $urandom_range(0, 300);
      endcase
      adc(bl, 1'b1);
      for (int g = 0; g < 4; g++) begin
        n_checks++;
        if (dout[g] !== dout_m[g]) begin
          n_fail++; $display("FAIL random it%0d bl%0d [%0d] got %0d expected %0d",
                             it, bl, g, dout[g], dout_m[g]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    en_set();
    for (int wl = 0; wl < 32; wl++) dac_write(wl, 8'd63, 1'b1);
    adc(0, 1'b1);
    rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== 6'd0) begin
        n_fail++; $display("FAIL mid_reset[%0d] got %0d expected 0", g, dout[g]);
      end
    end
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    adc(0, 1'b1);
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (dout[g] !== 6'd0) begin
        n_fail++; $display("FAIL after_reset[%0d] got %0d expected 0", g, dout[g]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; din = 8'd0; addr = 9'd0; clkdac = 1'b0; clkadc = 1'b0;
    clkreg = 4'd0; dinswreg = 4'd0; dacwl_sw = 1'b0; dacbl_sw2 = 1'b0;
    dischg = 1'b0; arst_wlreg = 1'b0; arst_enreg = 1'b0; aset_enreg = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_compute();
    test_full_scale();
    test_enables();
    test_clear_gating();
    test_edge_handling();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
